nt_node_seq_monitor: RTL and testbench

- Downstream consumer of the I2203 flop-chain subcircuit. Samples its serial output bit and deserialises it into WIDTH-bit words with a valid/ready handshake.
- Runs a sliding-window pattern matcher over the serial stream and raises a one-shot trigger after THRESH matches.
- Used as the observation/trigger stage for Nt_Node trojan-detection benchmarks.
- Shares the clock and reset nets of the upstream stage.

---
 rtl/nt_node_pkg.sv | 15 +
 rtl/nt_node_out_buf.sv | 57 +++++
 rtl/nt_node_seq_monitor.sv | 121 ++++++++++++
 tb/tb_nt_node_seq_monitor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nt_node_pkg.sv
// Shared types and default parameters for the Nt_Node serial monitor.
package nt_node_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_e;

    localparam int         DEF_WIDTH   = 8;
    localparam logic [7:0] DEF_PATTERN = 8'hA5;
    localparam int         DEF_THRESH  = 3;
    localparam int         DEF_CNT_W   = 4;

endpackage

// File: rtl/nt_node_out_buf.sv
// Single-entry valid/ready holding register; a capture that finds the slot
// still occupied (and not being drained) is dropped and flagged sticky.
module nt_node_out_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         cap_valid,
    input  logic [W-1:0] cap_data,
    input  logic         ready,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         ovf_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (clr) begin
            data_d  = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (cap_valid) begin
            if (!valid_q || ready) begin
                data_d  = cap_data;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/nt_node_seq_monitor.sv
// Serial observation stage: deserialises I2203 into words and fires a
// one-shot trigger once a sliding-window pattern has matched THRESH times.
module nt_node_seq_monitor
    import nt_node_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN),
    parameter int               THRESH  = DEF_THRESH,
    parameter int               CNT_W   = DEF_CNT_W
) (
    input  logic             I1294,
    input  logic             I1301,
    input  logic             I2203,
    input  logic             din_en,
    input  logic             clr,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] match_cnt,
    output logic             trig,
    output logic             fired,
    output logic             ovf
);

    localparam int BC_W   = $clog2(WIDTH);
    localparam int FILL_W = $clog2(WIDTH + 1);

    localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0]   BC_ONE    = BC_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_THR   = CNT_W'(THRESH);

    logic [WIDTH-1:0]  sreg_q, sreg_d, sreg_sh;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic              trig_q, trig_d;
    logic              fired_q, fired_d;
    logic              capture;

    always_comb begin
        sreg_sh   = {sreg_q[WIDTH-2:0], I2203};
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        capture   = 1'b0;

        if (din_en) begin
            sreg_d    = sreg_sh;
            bit_cnt_d = (bit_cnt_q == BC_LAST) ? '0 : bit_cnt_q + BC_ONE;
            fill_d    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_ONE;
            capture   = (bit_cnt_q == BC_LAST);
            // The window is only meaningful once it holds WIDTH real bits.
            if ((fill_d == FILL_FULL) && (sreg_sh == PATTERN) && (cnt_q != CNT_MAX))
                cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE:  if (din_en && (fill_d == FILL_FULL))
                          state_d = (cnt_d >= CNT_THR) ? ST_FIRED : ST_ARMED;
            ST_ARMED: if (cnt_d >= CNT_THR) state_d = ST_FIRED;
            ST_FIRED: state_d = ST_FIRED;
            default:  state_d = ST_IDLE;
        endcase

        if (clr) begin
            sreg_d    = '0;
            bit_cnt_d = '0;
            fill_d    = '0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
            capture   = 1'b0;
        end

        trig_d  = (state_d == ST_FIRED) && (state_q != ST_FIRED);
        fired_d = (state_d == ST_FIRED);
    end

    always_ff @(posedge I1294 or posedge I1301) begin
        if (I1301) begin
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            trig_q    <= 1'b0;
            fired_q   <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            trig_q    <= trig_d;
            fired_q   <= fired_d;
        end
    end

    nt_node_out_buf #(.W(WIDTH)) u_out_buf (
        .clk       (I1294),
        .rst       (I1301),
        .clr       (clr),
        .cap_valid (capture),
        .cap_data  (sreg_sh),
        .ready     (word_ready),
        .data_o    (word_o),
        .valid_o   (word_valid),
        .ovf_o     (ovf)
    );

    assign match_cnt = cnt_q;
    assign trig      = trig_q;
    assign fired     = fired_q;

endmodule

// File: tb/tb_nt_node_seq_monitor.sv
// Directed bench for nt_node_seq_monitor: default instance (pattern A5) and
// an overlap instance (pattern AA) share clock, reset and stimulus.
module tb_nt_node_seq_monitor;
    import nt_node_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_en = 1'b0;
    logic       clr = 1'b0;
    logic       word_ready = 1'b0;

    logic [7:0] word_o, word_o2;
    logic       word_valid, word_valid2;
    logic [3:0] match_cnt, match_cnt2;
    logic       trig, trig2, fired, fired2, ovf, ovf2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nt_node_seq_monitor dut (
        .I1294(clk), .I1301(rst), .I2203(din), .din_en(din_en), .clr(clr),
        .word_o(word_o), .word_valid(word_valid), .word_ready(word_ready),
        .match_cnt(match_cnt), .trig(trig), .fired(fired), .ovf(ovf)
    );

    nt_node_seq_monitor #(.PATTERN(8'hAA)) dut_aa (
        .I1294(clk), .I1301(rst), .I2203(din), .din_en(din_en), .clr(clr),
        .word_o(word_o2), .word_valid(word_valid2), .word_ready(word_ready),
        .match_cnt(match_cnt2), .trig(trig2), .fired(fired2), .ovf(ovf2)
    );

    task automatic shift_bit(input logic b);
        din    = b;
        din_en = 1'b1;
        @(negedge clk);
        din_en = 1'b0;
    endtask

    task automatic shift_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) shift_bit(v[i]);
    endtask

    task automatic idle(input int n);
        din_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({word_o, word_valid, match_cnt, trig, fired, ovf} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got word=%h v=%b cnt=%0d trig=%b fired=%b ovf=%b, expected all 0",
                     word_o, word_valid, match_cnt, trig, fired, ovf);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word;
        do_reset();
        word_ready = 1'b1;
        shift_bits(8'hA5, 4);
        idle(3);
        shift_bits(8'h50, 4);
        checks++;
        if (word_valid !== 1'b1 || word_o !== 8'hA5) begin
            errors++;
            $display("FAIL single_word: got v=%b word=%h expected v=1 word=a5", word_valid, word_o);
        end
        checks++;
        if (match_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_cnt: got %0d expected 1", match_cnt);
        end
        checks++;
        if (dut.state_q !== ST_ARMED || trig !== 1'b0 || fired !== 1'b0) begin
            errors++;
            $display("FAIL single_state: got st=%0d trig=%b fired=%b expected st=1 trig=0 fired=0",
                     dut.state_q, trig, fired);
        end
        idle(1);
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_consume: got v=%b expected 0", word_valid);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        word_ready = 1'b1;
        shift_bits(8'hA5, 8);
        shift_bits(8'hA5, 8);
        shift_bits(8'hA5, 7);
        checks++;
        if (match_cnt !== 4'd2 || trig !== 1'b0 || fired !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pre: got cnt=%0d trig=%b fired=%b expected 2,0,0", match_cnt, trig, fired);
        end
        shift_bit(1'b1);
        checks++;
        if (match_cnt !== 4'd3 || trig !== 1'b1 || fired !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fire: got cnt=%0d trig=%b fired=%b expected 3,1,1", match_cnt, trig, fired);
        end
        checks++;
        if (word_valid !== 1'b1 || word_o !== 8'hA5) begin
            errors++;
            $display("FAIL b2b_word: got v=%b word=%h expected 1 a5", word_valid, word_o);
        end
        idle(1);
        checks++;
        if (trig !== 1'b0 || fired !== 1'b1) begin
            errors++;
            $display("FAIL b2b_post: got trig=%b fired=%b expected 0,1", trig, fired);
        end
        shift_bits(8'hA5, 8);
        checks++;
        if (trig !== 1'b0 || fired !== 1'b1 || match_cnt !== 4'd4) begin
            errors++;
            $display("FAIL b2b_absorb: got trig=%b fired=%b cnt=%0d expected 0,1,4", trig, fired, match_cnt);
        end
    endtask

    task automatic test_overlap;
        do_reset();
        word_ready = 1'b1;
        shift_bits(8'hAA, 8);
        checks++;
        if (match_cnt2 !== 4'd1 || fired2 !== 1'b0 || word_o2 !== 8'hAA) begin
            errors++;
            $display("FAIL overlap_first: got cnt=%0d fired=%b word=%h expected 1,0,aa",
                     match_cnt2, fired2, word_o2);
        end
        shift_bits(8'hA0, 4);
        checks++;
        if (match_cnt2 !== 4'd3 || trig2 !== 1'b1 || fired2 !== 1'b1) begin
            errors++;
            $display("FAIL overlap_fire: got cnt=%0d trig=%b fired=%b expected 3,1,1", match_cnt2, trig2, fired2);
        end
        shift_bits(8'hA0, 4);
        checks++;
        if (match_cnt2 !== 4'd5 || trig2 !== 1'b0 || fired2 !== 1'b1) begin
            errors++;
            $display("FAIL overlap_end: got cnt=%0d trig=%b fired=%b expected 5,0,1", match_cnt2, trig2, fired2);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        word_ready = 1'b0;
        shift_bits(8'hA5, 8);
        shift_bits(8'h3C, 8);
        shift_bits(8'h0F, 8);
        checks++;
        if (word_valid !== 1'b1 || word_o !== 8'hA5 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: got v=%b word=%h ovf=%b expected 1 a5 1", word_valid, word_o, ovf);
        end
        word_ready = 1'b1;
        idle(1);
        checks++;
        if (word_valid !== 1'b0 || ovf !== 1'b1 || word_o !== 8'hA5) begin
            errors++;
            $display("FAIL ovf_drain: got v=%b ovf=%b word=%h expected 0 1 a5", word_valid, ovf, word_o);
        end
    endtask

    task automatic test_async_reset;
        // Entered with word_o=a5, ovf=1, match_cnt=1 from the overflow scenario.
        shift_bits(8'hFF, 5);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({word_o, word_valid, match_cnt, trig, fired, ovf} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got word=%h v=%b cnt=%0d trig=%b fired=%b ovf=%b, expected all 0",
                     word_o, word_valid, match_cnt, trig, fired, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        shift_bits(8'h3C, 8);
        checks++;
        if (word_valid !== 1'b1 || word_o !== 8'h3C || ovf !== 1'b0 || match_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_clean_word: got v=%b word=%h ovf=%b cnt=%0d expected 1 3c 0 0",
                     word_valid, word_o, ovf, match_cnt);
        end
    endtask

    task automatic test_clr_fired;
        do_reset();
        word_ready = 1'b0;
        shift_bits(8'hA5, 8);
        shift_bits(8'hA5, 8);
        shift_bits(8'hA5, 8);
        checks++;
        if (fired !== 1'b1 || ovf !== 1'b1 || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup: got fired=%b ovf=%b v=%b expected 1 1 1", fired, ovf, word_valid);
        end
        shift_bits(8'hA5, 7);
        din    = 1'b1;
        din_en = 1'b1;
        clr    = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
        din_en = 1'b0;
        checks++;
        if ({word_o, word_valid, match_cnt, trig, fired, ovf} !== 16'h0) begin
            errors++;
            $display("FAIL clr_outputs: got word=%h v=%b cnt=%0d trig=%b fired=%b ovf=%b, expected all 0",
                     word_o, word_valid, match_cnt, trig, fired, ovf);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL clr_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        word_ready = 1'b1;
        shift_bits(8'hA5, 8);
        checks++;
        if (word_valid !== 1'b1 || word_o !== 8'hA5 || match_cnt !== 4'd1 || dut.state_q !== ST_ARMED) begin
            errors++;
            $display("FAIL clr_rearm: got v=%b word=%h cnt=%0d st=%0d expected 1 a5 1 1",
                     word_valid, word_o, match_cnt, dut.state_q);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overlap();
        test_overflow();
        test_async_reset();
        test_clr_fired();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
